// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle W-bit adder/subtractor, CW bits per clock.
// One CW-bit adder slice with a registered carry; valid/ready on both sides.
module seq_addsub #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NCH  = W / CW;
  localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    s_q;
  logic            c_q;
  logic            sa_q;
  logic            sb_q;
  logic [CNTW-1:0] cnt_q;

  logic [CW-1:0]   a_ch;
  logic [CW-1:0]   b_ch;
  logic [CW:0]     csum;
  logic [W-1:0]    s_full;
  logic [W-1:0]    b_in;
  logic            last;
  logic            accept;
  logic            release_out;
  int              base;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_ready && in_valid;
  assign release_out = out_valid && out_ready;
  assign last        = (cnt_q == CNTW'(NCH - 1));
  assign b_in        = sub ? ~b : b;

  // Current chunk plus the partial sum with this chunk merged in,
  // so the last edge can load the complete result directly.
  always_comb begin
    base   = int'(cnt_q) * CW;
    a_ch   = a_q[base +: CW];
    b_ch   = b_q[base +: CW];
    csum   = (CW+1)'(a_ch) + (CW+1)'(b_ch) + (CW+1)'(c_q);
    s_full = s_q;
    s_full[base +: CW] = csum[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)      state_nx = RUN;
      RUN:  if (last)        state_nx = DONE;
      DONE: if (release_out) state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b_in;
      c_q   <= sub ? ~cin : cin;
      sa_q  <= a[W-1];
      sb_q  <= b_in[W-1];
      cnt_q <= '0;
    end else if (state == RUN) begin
      s_q   <= s_full;
      c_q   <= csum[CW];
      cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Visible result only updates on the final chunk edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (state == RUN && last) begin
      y    <= s_full;
      cout <= csum[CW];
      zero <= (s_full == '0);
      ovf  <= (sa_q == sb_q) && (s_full[W-1] != sa_q);
    end
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the single-cycle combinational W-bit adder.
- Processes the W-bit operands CW bits per clock, LSB chunk first, through one CW-bit adder slice with a registered carry.
- Adds carry-in, subtract mode, status flags (carry, signed overflow, zero) and valid/ready handshakes on both input and output.
- Sits between an operand producer and a result consumer in the datapath. Trades latency for adder area.

Parameters:
- W, 16, operand/result width in bits.
- CW, 4, chunk width processed per cycle. Must divide W. CW==W gives a one-chunk pass.
- NCH, W/CW, derived localparam: number of chunks. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept an operation.
- a  in  W  operand A, unsigned/two's complement.
- b  in  W  operand B.
- cin  in  1  carry-in; borrow-in when sub=1.
- sub  in  1  0: y=a+b+cin. 1: y=a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- y  out  W  result, modulo 2^W.
- cout  out  1  carry-out. When sub=1 this is NOT-borrow (1 = no borrow).
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  y==0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1 after reset; out_valid=0; y=0, cout=0, ovf=0, zero=0; chunk counter=0; internal operand/carry registers=0. Reset mid-RUN or mid-DONE aborts the operation; no result is produced.
- FSM states IDLE, RUN, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE: on an edge with in_valid=1:
  - latch A=a, B'=(sub ? ~b : b), carry=(sub ? ~cin : cin), sign bits a[W-1] and B'[W-1];
  - counter=0; go to RUN.
- RUN: each edge adds chunk k: {c, S[k*CW+:CW]} = A[k*CW+:CW] + B'[k*CW+:CW] + carry; carry<=c; counter++.
  - On the edge processing chunk NCH-1, go to DONE and load y=S, cout=final carry, zero=(S==0).
  - On the same edge load ovf=(a[W-1]==B'[W-1]) && (S[W-1]!=a[W-1]).
- Latency: acceptance edge E0. out_valid is high after edge E_NCH (4 cycles for defaults; 1 cycle when CW==W). Throughput: one op per NCH+2 cycles minimum.
- DONE: y/cout/ovf/zero held stable while out_valid=1 and out_ready=0 (unbounded backpressure). On an edge with out_ready=1: out_valid<=0, go to IDLE; y and flags keep their last values until the next DONE load.
- y and flags never change during RUN; partial sums stay internal.
- in_valid/a/b/cin/sub changes while not in IDLE are ignored. Operands need only be stable on the acceptance edge.
- No same-cycle accept in DONE: in_ready is 0 there, even if out_ready=1.
- Width rule: all sums modulo 2^W. The carry chain crosses chunk boundaries only through the carry register.

Test Plan (W=16, CW=4):
- Add: a=0x0001, b=0x0002, cin=0, sub=0 -> y=0x0003, cout=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after acceptance; in_ready=0 during those cycles.
- Wrap/carry across all chunks: a=0xFFFF, b=0x0001 -> y=0x0000, cout=1, ovf=0, zero=1.
- Signed overflow and cin:
  - a=0x7FFF, b=0x0000, cin=1 -> y=0x8000, ovf=1, cout=0.
  - a=0x0FFF, b=0x0000, cin=1 -> y=0x1000, ovf=0.
- Subtract:
  - a=0x0000, b=0xABCD, sub=1, cin=0 -> y=0x5433, cout=0 (borrow), ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> y=0x7FFF, cout=1, ovf=1.
  - a=0x1234, b=0x1233, sub=1, cin=1 -> y=0x0000, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new operands -> y/flags/out_valid stay stable, new op not accepted. Then raise out_ready -> out_valid=0 next cycle, in_ready=1; the next op is accepted and produces the correct result.
- Reset mid-RUN: assert rst_n=0 asynchronously two cycles into an op -> outputs immediately 0, out_valid never rises for that op, in_ready=1 after release. A following add 0x0001+0x0002 yields 0x0003.
